// File: rtl/coin_pkg.sv
// Shared coin definitions: denomination index, coin values, credit limit and
// the change dispenser state encoding.
package coin_pkg;

  localparam logic [1:0] COIN_NICKEL  = 2'd0;
  localparam logic [1:0] COIN_DIME    = 2'd1;
  localparam logic [1:0] COIN_QUARTER = 2'd2;
  localparam logic [1:0] COIN_DOLLAR  = 2'd3;

  localparam int MAX_CREDIT = 999;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    ISSUE,
    DONE
  } dispState_t;

  // Face value in cents of each denomination index
  function automatic logic [6:0] coinValue(input logic [1:0] coinIdx);
    case (coinIdx)
      COIN_NICKEL:  return 7'd5;
      COIN_DIME:    return 7'd10;
      COIN_QUARTER: return 7'd25;
      default:      return 7'd100;
    endcase
  endfunction

endpackage

// File: rtl/coin_selector.sv
// Greedy coin chooser: largest denomination that fits the remainder and is
// still in stock.
module coin_selector
  import coin_pkg::*;
#(
  parameter int AMT_W = 11
) (
  input  logic [AMT_W-1:0] remaining,
  input  logic [3:0]       invNonzero,
  output logic             found,
  output logic [1:0]       coin_type,
  output logic [AMT_W-1:0] value
);

  // Scan from dollar down to nickel; the first hit wins
  always_comb begin
    found     = 1'b0;
    coin_type = COIN_NICKEL;
    value     = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!found && invNonzero[i] && (remaining >= AMT_W'(coinValue(2'(i))))) begin
        found     = 1'b1;
        coin_type = 2'(i);
        value     = AMT_W'(coinValue(2'(i)));
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin at a time over a valid/ready handshake,
// tracking per-denomination inventory and reporting any unpaid remainder.
module change_dispenser
  import coin_pkg::*;
#(
  parameter int AMT_W    = 11,
  parameter int INV_W    = 8,
  parameter int INV_INIT = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [AMT_W-1:0]   amount,
  input  logic               refill,
  output logic               coin_valid,
  output logic [1:0]         coin_type,
  input  logic               coin_ready,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [AMT_W-1:0]   short_out,
  output logic [4*INV_W-1:0] inv_level
);

  dispState_t       state, stateNext;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] coinValueReg;
  logic [1:0]       coinTypeReg;
  logic [AMT_W-1:0] shortReg;
  logic             errReg;
  logic [INV_W-1:0] inv [4];

  logic [3:0]       invNonzero;
  logic             selFound;
  logic [1:0]       selType;
  logic [AMT_W-1:0] selValue;
  logic             badAmount;

  logic loadAmount, doRefill, latchCoin, takeCoin, setShort, errNext;

  always_comb begin
    invNonzero = '0;
    for (int i = 0; i < 4; i++) begin
      invNonzero[i] = (inv[i] != '0);
    end
  end

  assign badAmount = (amount > AMT_W'(MAX_CREDIT)) || ((amount % AMT_W'(5)) != '0);

  coin_selector #(
    .AMT_W(AMT_W)
  ) selector (
    .remaining (remaining),
    .invNonzero(invNonzero),
    .found     (selFound),
    .coin_type (selType),
    .value     (selValue)
  );

  // Next-state and datapath strobes; a zero remainder simply finds no coin
  always_comb begin
    stateNext  = state;
    loadAmount = 1'b0;
    doRefill   = 1'b0;
    latchCoin  = 1'b0;
    takeCoin   = 1'b0;
    setShort   = 1'b0;
    errNext    = 1'b0;
    case (state)
      IDLE: begin
        doRefill = refill;
        if (start) begin
          if (badAmount) begin
            errNext = 1'b1;
          end else begin
            loadAmount = 1'b1;
            stateNext  = SELECT;
          end
        end
      end
      SELECT: begin
        if (selFound) begin
          latchCoin = 1'b1;
          stateNext = ISSUE;
        end else begin
          setShort  = 1'b1;
          stateNext = DONE;
        end
      end
      ISSUE: begin
        if (coin_ready) begin
          takeCoin  = 1'b1;
          stateNext = SELECT;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      remaining    <= '0;
      coinValueReg <= '0;
      coinTypeReg  <= COIN_NICKEL;
      shortReg     <= '0;
      errReg       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        inv[i] <= INV_W'(INV_INIT);
      end
    end else begin
      state  <= stateNext;
      errReg <= errNext;
      if (loadAmount) begin
        remaining <= amount;
        shortReg  <= '0;
      end
      if (latchCoin) begin
        coinTypeReg  <= selType;
        coinValueReg <= selValue;
      end
      if (setShort) begin
        shortReg <= remaining;
      end
      // The selector only offers stocked coins that fit, so neither side can wrap
      if (takeCoin) begin
        remaining <= remaining - coinValueReg;
        if (inv[coinTypeReg] != '0) begin
          inv[coinTypeReg] <= inv[coinTypeReg] - INV_W'(1);
        end
      end
      if (doRefill) begin
        for (int i = 0; i < 4; i++) begin
          inv[i] <= INV_W'(INV_INIT);
        end
      end
    end
  end

  assign coin_valid = (state == ISSUE);
  assign coin_type  = coinTypeReg;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign err        = errReg;
  assign short_out  = shortReg;
  assign inv_level  = {inv[3], inv[2], inv[1], inv[0]};

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy payout model queues the
// expected coins, and monitors pop them as the ejector handshakes occur.
module tb_change_dispenser;

  localparam int AMT_W = 11;
  localparam int INV_W = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [AMT_W-1:0]   amount = '0;
  logic               refill = 1'b0;
  logic               coin_ready = 1'b0;
  logic               coin_valid, busy, done, err;
  logic [1:0]         coin_type;
  logic [AMT_W-1:0]   short_out;
  logic [4*INV_W-1:0] inv_level;

  logic               startB = 1'b0;
  logic [AMT_W-1:0]   amountB = '0;
  logic               refillB = 1'b0;
  logic               coinReadyB = 1'b0;
  logic               coinValidB, busyB, doneB, errB;
  logic [1:0]         coinTypeB;
  logic [AMT_W-1:0]   shortOutB;
  logic [4*INV_W-1:0] invLevelB;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int startCyc = 0;
  int startCycB = 0;
  int modelInv[4];
  int modelInvB[4];
  int expShort = 0;
  int expShortB = 0;
  int coinVal[4] = '{5, 10, 25, 100};
  logic [1:0] expCoin[$];
  logic [1:0] expCoinB[$];
  int hsCycles[$];

  change_dispenser dut (
    .clk(clk), .rst(rst), .start(start), .amount(amount), .refill(refill),
    .coin_valid(coin_valid), .coin_type(coin_type), .coin_ready(coin_ready),
    .busy(busy), .done(done), .err(err), .short_out(short_out), .inv_level(inv_level)
  );

  change_dispenser #(.INV_INIT(1)) dutB (
    .clk(clk), .rst(rst), .start(startB), .amount(amountB), .refill(refillB),
    .coin_valid(coinValidB), .coin_type(coinTypeB), .coin_ready(coinReadyB),
    .busy(busyB), .done(doneB), .err(errB), .short_out(shortOutB), .inv_level(invLevelB)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every presented coin must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && coin_valid) begin
      checks++;
      if (expCoin.size() == 0) begin
        errors++;
        $display("[TB] FAIL coin_unexpected: got type %0d, expected no coin", coin_type);
      end else if (coin_type !== expCoin[0]) begin
        errors++;
        $display("[TB] FAIL coin_type: got %0d, expected %0d", coin_type, expCoin[0]);
      end
      if (coin_ready && expCoin.size() != 0) begin
        void'(expCoin.pop_front());
        hsCycles.push_back(cyc - startCyc);
      end
    end
    if (!rst && coinValidB) begin
      checks++;
      if (expCoinB.size() == 0) begin
        errors++;
        $display("[TB] FAIL coinB_unexpected: got type %0d, expected no coin", coinTypeB);
      end else if (coinTypeB !== expCoinB[0]) begin
        errors++;
        $display("[TB] FAIL coinB_type: got %0d, expected %0d", coinTypeB, expCoinB[0]);
      end
      if (coinReadyB && expCoinB.size() != 0) void'(expCoinB.pop_front());
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4*INV_W-1:0] packInv(input bit forB);
    if (forB) return {8'(modelInvB[3]), 8'(modelInvB[2]), 8'(modelInvB[1]), 8'(modelInvB[0])};
    return {8'(modelInv[3]), 8'(modelInv[2]), 8'(modelInv[1]), 8'(modelInv[0])};
  endfunction

  task automatic modelPayout(input bit forB, input int amt, output int shortAmt);
    int rem = amt;
    bit found;
    do begin
      found = 1'b0;
      for (int t = 3; t >= 0; t--) begin
        if (!found && vals_ok(forB, t, rem)) begin
          found = 1'b1;
          rem -= coinVal[t];
          if (forB) begin
            expCoinB.push_back(t[1:0]);
            modelInvB[t]--;
          end else begin
            expCoin.push_back(t[1:0]);
            modelInv[t]--;
          end
        end
      end
    end while (found);
    shortAmt = rem;
  endtask

  function automatic bit vals_ok(input bit forB, input int t, input int rem);
    int stock = forB ? modelInvB[t] : modelInv[t];
    return (stock > 0) && (coinVal[t] <= rem);
  endfunction

  task automatic applyStimulus(input int amt, input bit withRefill);
    if (withRefill) for (int i = 0; i < 4; i++) modelInv[i] = 20;
    if (amt <= 999 && (amt % 5) == 0) modelPayout(1'b0, amt, expShort);
    hsCycles.delete();
    amount = AMT_W'(amt);
    start  = 1'b1;
    refill = withRefill;
    step();
    start    = 1'b0;
    refill   = 1'b0;
    startCyc = cyc - 1;
  endtask

  task automatic waitDone(input int limit, output int doneAt);
    doneAt = -1;
    for (int i = 0; i < limit && doneAt < 0; i++) begin
      if (done === 1'b1) doneAt = cyc - startCyc;
      else step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      modelInv[i]  = 20;
      modelInvB[i] = 1;
    end
    checks++; if (coin_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_coin_valid: got %b, expected 0", coin_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b, expected 0", err); end
    checks++; if (coin_type !== 2'd0) begin errors++; $display("[TB] FAIL reset_coin_type: got %0d, expected 0", coin_type); end
    checks++; if (short_out !== '0) begin errors++; $display("[TB] FAIL reset_short: got %0d, expected 0", short_out); end
    checks++; if (inv_level !== 32'h14141414) begin errors++; $display("[TB] FAIL reset_inv: got %h, expected 14141414", inv_level); end
    checks++; if (invLevelB !== 32'h01010101) begin errors++; $display("[TB] FAIL reset_invB: got %h, expected 01010101", invLevelB); end
  endtask

  task automatic test_greedy65();
    int d;
    coin_ready = 1'b1;
    applyStimulus(65, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL g65_busy_c1: got %b, expected 1", busy); end
    waitDone(20, d);
    checks++; if (d !== 10) begin errors++; $display("[TB] FAIL g65_done_cycle: got %0d, expected 10", d); end
    checks++; if (short_out !== AMT_W'(expShort)) begin errors++; $display("[TB] FAIL g65_short: got %0d, expected %0d", short_out, expShort); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= hsCycles.size() || hsCycles[i] !== 2 + 2 * i) begin
        errors++;
        $display("[TB] FAIL g65_coin_cycle%0d: got %0d, expected %0d", i, (i < hsCycles.size()) ? hsCycles[i] : -1, 2 + 2 * i);
      end
    end
    checks++; if (inv_level[23:16] !== 8'd18) begin errors++; $display("[TB] FAIL g65_quarters: got %0d, expected 18", inv_level[23:16]); end
    checks++; if (inv_level !== packInv(1'b0)) begin errors++; $display("[TB] FAIL g65_inv: got %h, expected %h", inv_level, packInv(1'b0)); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL g65_busy_after: got %b, expected 0", busy); end
  endtask

  task automatic test_shortfall();
    int d = -1;
    coinReadyB = 1'b1;
    modelPayout(1'b1, 190, expShortB);
    amountB = AMT_W'(190);
    startB  = 1'b1;
    step();
    startB    = 1'b0;
    startCycB = cyc - 1;
    for (int i = 0; i < 20 && d < 0; i++) begin
      if (doneB === 1'b1) d = cyc - startCycB;
      else step();
    end
    checks++; if (d !== 10) begin errors++; $display("[TB] FAIL short_done_cycle: got %0d, expected 10", d); end
    checks++; if (shortOutB !== AMT_W'(50)) begin errors++; $display("[TB] FAIL short_value: got %0d, expected 50", shortOutB); end
    checks++; if (invLevelB !== packInv(1'b1) || invLevelB !== '0) begin errors++; $display("[TB] FAIL short_inv: got %h, expected 0", invLevelB); end
    checks++; if (expCoinB.size() != 0) begin errors++; $display("[TB] FAIL short_coins_left: got %0d, expected 0", expCoinB.size()); end
    step();
    coinReadyB = 1'b0;
  endtask

  task automatic test_stall();
    int d;
    coin_ready = 1'b0;
    applyStimulus(25, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (coin_valid !== 1'b1 || coin_type !== 2'd2) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got valid %b type %0d, expected valid 1 type 2", i, coin_valid, coin_type);
      end
      step();
    end
    coin_ready = 1'b1;
    waitDone(10, d);
    checks++; if (d !== 9) begin errors++; $display("[TB] FAIL stall_done_cycle: got %0d, expected 9", d); end
    checks++; if (hsCycles.size() != 1 || hsCycles[0] !== 7) begin errors++; $display("[TB] FAIL stall_handshakes: got %0d, expected 1 at cycle 7", hsCycles.size()); end
    checks++; if (inv_level !== packInv(1'b0)) begin errors++; $display("[TB] FAIL stall_inv: got %h, expected %h", inv_level, packInv(1'b0)); end
    step();
  endtask

  task automatic test_reject();
    int bad[2] = '{7, 1000};
    for (int k = 0; k < 2; k++) begin
      applyStimulus(bad[k], 1'b0);
      checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL reject_err_%0d: got err %b busy %b, expected err 1 busy 0", bad[k], err, busy); end
      step();
      checks++; if (err !== 1'b0 || busy !== 1'b0 || coin_valid !== 1'b0) begin errors++; $display("[TB] FAIL reject_after_%0d: got err %b busy %b valid %b, expected all 0", bad[k], err, busy, coin_valid); end
      checks++; if (inv_level !== packInv(1'b0)) begin errors++; $display("[TB] FAIL reject_inv_%0d: got %h, expected %h", bad[k], inv_level, packInv(1'b0)); end
      checks++; if (short_out !== AMT_W'(expShort)) begin errors++; $display("[TB] FAIL reject_short_%0d: got %0d, expected %0d", bad[k], short_out, expShort); end
    end
  endtask

  task automatic test_zero();
    int d;
    applyStimulus(0, 1'b0);
    waitDone(10, d);
    checks++; if (d !== 2) begin errors++; $display("[TB] FAIL zero_done_cycle: got %0d, expected 2", d); end
    checks++; if (short_out !== '0 || hsCycles.size() != 0) begin errors++; $display("[TB] FAIL zero_result: got short %0d coins %0d, expected 0 and 0", short_out, hsCycles.size()); end
    step();
  endtask

  task automatic test_back_to_back();
    int d;
    coin_ready = 1'b1;
    applyStimulus(40, 1'b0);
    amount = AMT_W'(5);
    start  = 1'b1;
    step();
    start = 1'b0;
    waitDone(20, d);
    checks++; if (d !== 8) begin errors++; $display("[TB] FAIL b2b_first_done: got %0d, expected 8", d); end
    step();
    applyStimulus(15, 1'b0);
    waitDone(20, d);
    checks++; if (d !== 6) begin errors++; $display("[TB] FAIL b2b_second_done: got %0d, expected 6", d); end
    checks++; if (inv_level !== packInv(1'b0)) begin errors++; $display("[TB] FAIL b2b_inv: got %h, expected %h", inv_level, packInv(1'b0)); end
    checks++; if (expCoin.size() != 0) begin errors++; $display("[TB] FAIL b2b_coins_left: got %0d, expected 0", expCoin.size()); end
    step();
  endtask

  task automatic test_reset_midpayout();
    bit sawDone = 1'b0;
    coin_ready = 1'b1;
    applyStimulus(200, 1'b0);
    step();
    step();
    step();
    checks++; if (coin_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_second_coin: got valid %b, expected 1", coin_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    expCoin.delete();
    for (int i = 0; i < 4; i++) modelInv[i] = 20;
    checks++; if (coin_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_state: got valid %b busy %b done %b, expected 0 0 0", coin_valid, busy, done); end
    checks++; if (inv_level !== packInv(1'b0)) begin errors++; $display("[TB] FAIL midrst_inv: got %h, expected %h", inv_level, packInv(1'b0)); end
    for (int i = 0; i < 3; i++) begin
      if (done === 1'b1 || coin_valid === 1'b1) sawDone = 1'b1;
      step();
    end
    checks++; if (sawDone !== 1'b0) begin errors++; $display("[TB] FAIL midrst_quiet: got activity %b, expected 0", sawDone); end
  endtask

  task automatic test_refill();
    int d;
    coin_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      applyStimulus(5, 1'b0);
      waitDone(10, d);
      checks++; if (d !== 4) begin errors++; $display("[TB] FAIL drain%0d_done: got %0d, expected 4", n, d); end
      step();
    end
    checks++; if (inv_level[7:0] !== 8'd0) begin errors++; $display("[TB] FAIL drain_nickels: got %0d, expected 0", inv_level[7:0]); end
    applyStimulus(5, 1'b0);
    waitDone(10, d);
    checks++; if (d !== 2 || short_out !== AMT_W'(5)) begin errors++; $display("[TB] FAIL empty_short: got done %0d short %0d, expected 2 and 5", d, short_out); end
    step();
    applyStimulus(5, 1'b1);
    waitDone(10, d);
    checks++; if (d !== 4 || short_out !== '0) begin errors++; $display("[TB] FAIL refill_pay: got done %0d short %0d, expected 4 and 0", d, short_out); end
    checks++; if (inv_level !== 32'h14141413) begin errors++; $display("[TB] FAIL refill_inv: got %h, expected 14141413", inv_level); end
    checks++; if (expCoin.size() != 0) begin errors++; $display("[TB] FAIL refill_coins_left: got %0d, expected 0", expCoin.size()); end
    step();
  endtask

  initial begin
    test_reset();
    test_greedy65();
    test_shortfall();
    test_stall();
    test_reject();
    test_zero();
    test_back_to_back();
    test_reset_midpayout();
    test_refill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Downstream of the coin-credit manager, this block pays out the change value it produces after a purchase. It takes a cents amount and issues coins one at a time to the coin-ejector mechanism over a valid/ready handshake, using greedy largest-coin-first selection. It tracks per-denomination inventory and reports any shortfall it cannot pay.

## Interface
Parameters:
- AMT_W, 11, width of amount and shortfall (cents, matches credit width)
- INV_W, 8, width of each inventory counter
- INV_INIT, 20, per-denomination count loaded on reset and on refill

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset rst, synchronous, active-high
- start  in  1  one-cycle request; samples amount
- amount  in  AMT_W  change to pay, cents
- refill  in  1  reload all inventories to INV_INIT (honoured in IDLE only)
- coin_valid  out  1  coin_type is presented to ejector
- coin_type  out  2  0 nickel, 1 dime, 2 quarter, 3 dollar
- coin_ready  in  1  ejector accepts coin this cycle
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of a payout
- err  out  1  one-cycle pulse on rejected request
- short_out  out  AMT_W  unpaid remainder of last payout, held until next accepted start
- inv_level  out  4*INV_W  inventory, {dollar, quarter, dime, nickel}

## Operation
- FSM states: IDLE, SELECT, ISSUE, DONE.
- IDLE: on start, if amount > 999 or amount % 5 != 0, pulse err next cycle and stay IDLE. Otherwise latch remaining = amount, clear short_out, go SELECT. start while not IDLE is ignored.
- SELECT: if remaining == 0, go DONE with short_out = 0. Else pick the largest coin with value <= remaining and inventory != 0. Priority: dollar(100), quarter(25), dime(10), nickel(5). If a coin is found, register coin_type and go ISSUE. If none is found, set short_out = remaining and go DONE.
- ISSUE: coin_valid = 1 and coin_type stays constant until the handshake. When coin_valid && coin_ready: remaining -= value, that inventory decrements by 1, go SELECT.
- DONE: done = 1 for exactly one cycle, then IDLE.
- refill: all four counters are set to INV_INIT in the cycle after refill is sampled in IDLE. refill in any other state is ignored. If start and refill are sampled together in IDLE, both take effect; SELECT sees the refilled inventory.
- Arithmetic: remaining is AMT_W unsigned and can never underflow, since a coin is chosen only when value <= remaining. Inventory never decrements below 0.
- Reset: state goes to IDLE. coin_valid, done, err, busy = 0; coin_type = 0; short_out = 0; remaining = 0; every inventory counter = INV_INIT.
- Reset mid-payout abandons the payout: coins already handshaken stay counted, nothing further is issued, and no done pulse is produced.

## Timing
- start sampled at edge 0; busy = 1 from cycle 1 (SELECT); first coin_valid in cycle 2.
- Handshake at cycle k; SELECT at k+1; next coin_valid at k+2. Minimum 2 cycles per coin.
- After the last handshake at cycle k, SELECT runs at k+1 and done = 1 at k+2. IDLE and busy = 0 follow at k+3.
- amount == 0: done in cycle 2 with short_out = 0 and no coins issued.
- err is asserted the cycle after the rejected start; busy never rises.
- coin_ready is ignored outside ISSUE. coin_ready may be held high continuously.
- short_out and inv_level are registered, and update on the same edge as their cause.

## Structure
- Shared package coin_pkg:
  - coin type encoding constants COIN_NICKEL..COIN_DOLLAR (0..3, the team-wide coin index)
  - coin values 5/10/25/100 as a function or constant array
  - MAX_CREDIT = 999
  - the dispenser state enum
- Sub-module coin_selector (combinational): inputs are remaining and the four inventory-nonzero flags. Outputs are found, coin_type and value. It implements the greedy priority, keeping the FSM module free of selection logic.

## Test plan
- amount 65, full inventory → quarter, quarter, dime, nickel with coin_ready held 1. Coins at cycles 2, 4, 6, 8; done at cycle 10; short_out 0; quarter inventory INV_INIT-2.
- INV_INIT=1, amount 190 → dollar, quarter, dime, nickel; done; short_out 50; all inventories 0.
- amount 25, coin_ready low for 5 cycles → coin_valid held high and coin_type = 2 held stable throughout; single handshake; inventory decrements exactly once.
- amount 7, then amount 1000 → err pulse for each, busy stays 0, no coin_valid, inventory unchanged.
- amount 200, rst asserted during the second coin's ISSUE → next cycle coin_valid 0, state IDLE, no done pulse, inventories INV_INIT.
- Drain the nickels, then refill + start(5) in the same cycle → one nickel issued, done, short_out 0.
